result_readback: RTL
====================

Name: result_readback

Overview:
- Post-run result reader for the RISCV CPU's byte-addressed data memory.
- On a rising edge of the CPU `done`, it reads the M result words stored big-endian from address M*N*4+N*4 upward.
- It streams them out one word per valid/ready transfer, optionally followed by a snapshot word of the performance counters.
- It is the hardware counterpart to the bench-side result check, used for on-board readout.

Parameters:
- M, 3, matrix rows; this is also the number of result words.
- N, 4, matrix columns.
- WIDTH, 32, word width. Fixed at 4 bytes; any other value is illegal.
- ADDR_W, 8, data memory byte-address width.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- done  in  1  CPU end-of-program flag.
- clock_count  in  16  CPU cycle counter.
- instr_cnt  in  16  CPU retired-instruction counter.
- mem_addr  out  ADDR_W  data memory byte read address.
- mem_rd  out  1  read strobe.
- mem_rdata  in  8  read byte. Registered memory: valid one cycle after its address is presented with mem_rd high.
- out_data  out  WIDTH  assembled word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts.
- out_last  out  1  marks the final word of the stream.
- busy  out  1  high from trigger until the last word is accepted.

Behaviour:
- Reset is synchronous, active-high, on CLOCK_50. Reset values:
  - state=IDLE
  - out_valid=0, out_last=0, out_data=0, busy=0, mem_rd=0, mem_addr=0
  - word index=0, byte index=0
  - done_q=1, so a done already high at reset does not trigger.
- Trigger: done=1 and done_q=0 while in IDLE.
  - At that edge, snapshot stats={clock_count,instr_cnt}, set word index=0, enter FETCH, busy=1.
- FETCH (4 cycles):
  - mem_rd=1; mem_addr=BASE+4*w+k for k=0..3, driven combinationally.
  - BASE = M*N*4+N*4 = 64 at defaults.
- Byte capture: each edge after an address issue shifts mem_rdata into the low byte of the assembly register.
  - Byte k=0 ends up as bits [31:24], i.e. big-endian.
- CAPTURE (1 cycle): mem_rd=0; the last byte is shifted in; then enter PRESENT.
- Latency: out_valid rises 5 edges after the trigger edge, and 5 edges after each accepted word for the next one.
- PRESENT:
  - out_valid=1. out_data and out_last are held stable until out_valid&&out_ready at a rising edge.
  - On that transfer, if more words remain: w++, go to FETCH, out_valid=0 in the next cycle.
  - Otherwise go to IDLE with busy=0.
- No combinational ready->valid path. out_valid never drops without a transfer, except on reset.
- out_last: high with the last result word, or with the stats word when RB_STATS_EN is defined.
- done activity while busy is ignored. A new readback needs done to return low and then rise again. done_q updates every cycle.
- Reset mid-operation aborts immediately to the reset state. The partial word is discarded and no out_last is emitted.
- Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W. Configurations where BASE+4*M > 2^ADDR_W are illegal.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro: RB_STATS_EN.
- Defined: after result word M-1 is accepted, a STATS state presents out_data={clock_count,instr_cnt} as snapshotted at the trigger, with out_last=1.
  - It follows the same handshake with no memory access, and is valid on the edge after the last result transfer.
  - Stream length is M+1.
- Undefined: the stream is M words, out_last is on word M-1, and no snapshot register is present.

Decomposition:
- Package rb_pkg:
  - State encoding IDLE/FETCH/CAPTURE/PRESENT/STATS.
  - BYTES_PER_WORD=4.
  - Function result_base(M,N)=M*N*4+N*4.
- One sub-module, rb_word_assembler: a 4-byte big-endian shift register with clear and shift enable.
- The FSM and handshake stay in result_readback.

Test Plan:
- Basic readback:
  - Stimulus: memory bytes 64..75 = 00 00 00 0A, FF FF FF FE, 00 00 01 00; out_ready=1; raise done.
  - Response: words 0x0000000A, 0xFFFFFFFE, 0x00000100; out_last on the third; mem_addr sequence 64..75; first out_valid 5 edges after the trigger.
- Backpressure:
  - Stimulus: same data; out_ready low for 7 cycles on each word.
  - Response: out_data and out_valid stable throughout; no addresses issued while in PRESENT; same 3 words delivered.
- Stats (RB_STATS_EN defined):
  - Stimulus: clock_count=500, instr_cnt=100 at trigger; counters then change.
  - Response: fourth word 0x01F40064 with out_last; the third word has out_last=0.
- Re-trigger and level hold:
  - Stimulus: done held high after completion; pulse done during busy.
  - Response: no second stream. A fresh low-to-high done starts exactly one new stream.
- Reset mid-operation:
  - Stimulus: assert reset during FETCH of word 1 with done still high; release reset.
  - Response: all outputs 0 next cycle; no stream until done falls and rises again.
- Reset with done high:
  - Stimulus: done=1 throughout reset and after release.
  - Response: busy stays 0 and no readback occurs.

Source files
------------

// File: rtl/rb_pkg.sv
// ---------------------------------------------------------------------------
// rb_pkg
// Shared definitions for the result readback block: the readback FSM state
// encoding, the fixed word size in bytes, and the helper that locates the
// result matrix in the CPU data memory.
//
// Optional feature macro used by the importing files: RB_STATS_EN
// ---------------------------------------------------------------------------
package rb_pkg;

    // Result words are always 4 bytes wide; the assembler and the address
    // stepping both rely on this.
    localparam int BYTES_PER_WORD = 4;

    // Readback FSM states. STATS is only reachable when RB_STATS_EN is set.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        PRESENT = 3'd3,
        STATS   = 3'd4
    } rb_state_t;

    // The CPU program places the M result words directly after the MxN
    // input matrix and the N-element vector, so the first result byte sits
    // at M*N*4 + N*4.
    function automatic int result_base(input int m, input int n);
        return m * n * BYTES_PER_WORD + n * BYTES_PER_WORD;
    endfunction

endpackage

// File: rtl/rb_word_assembler.sv
// ---------------------------------------------------------------------------
// rb_word_assembler
// Four-byte big-endian shift register. Each enabled shift pushes the new
// byte into the low end, so the first byte shifted in ends up in the most
// significant byte once four shifts have happened.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset, clears the word
//   clear    in   synchronous clear before a new word is assembled
//   shift    in   shift byte_in into the low byte
//   byte_in  in   8-bit byte from the data memory
//   word     out  assembled word (8*BYTES_PER_WORD bits)
// ---------------------------------------------------------------------------
module rb_word_assembler
    import rb_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          shift,
    input  logic [7:0]                    byte_in,
    output logic [8*BYTES_PER_WORD-1:0]   word
);

    // Shift register holding the word under construction. Reset and clear
    // take priority so a half-built word never leaks into the next one.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word <= '0;
        end else if (shift) begin
            word <= {word[8*BYTES_PER_WORD-9:0], byte_in};
        end
    end

endmodule

// File: rtl/result_readback.sv
// ---------------------------------------------------------------------------
// result_readback
// Post-run reader for the RISC-V CPU's byte-addressed data memory. When the
// CPU's done flag rises, the M big-endian result words starting at
// result_base(M,N) are fetched byte by byte, assembled, and streamed out one
// word per valid/ready transfer. With RB_STATS_EN defined, a final word
// {clock_count, instr_cnt} captured at the trigger follows the results.
//
// Parameters:
//   M       number of matrix rows = number of result words
//   N       number of matrix columns
//   WIDTH   output word width, must be 32
//   ADDR_W  data memory byte-address width
//
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   done         in   CPU end-of-program flag (rising edge triggers)
//   clock_count  in   CPU cycle counter
//   instr_cnt    in   CPU retired-instruction counter
//   mem_addr     out  data memory byte read address
//   mem_rd       out  data memory read strobe
//   mem_rdata    in   read byte, valid one cycle after the address
//   out_data     out  assembled output word
//   out_valid    out  out_data is valid
//   out_ready    in   consumer accepts the current word
//   out_last     out  final word of the stream
//   busy         out  high from trigger until the last word is accepted
//
// Optional feature macro: RB_STATS_EN (append the stats snapshot word)
// ---------------------------------------------------------------------------
module result_readback
    import rb_pkg::*;
#(
    parameter int M      = 3,
    parameter int N      = 4,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              done,
    input  logic [15:0]       clock_count,
    input  logic [15:0]       instr_cnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    localparam int WORD_W = (M > 1) ? $clog2(M) : 1;
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(result_base(M, N));
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(M - 1);

    rb_state_t         state;
    rb_state_t         state_next;
    logic [WORD_W-1:0] word_idx;
    logic [WORD_W-1:0] word_next;
    logic [1:0]        byte_idx;
    logic [1:0]        byte_next;
    logic              done_q;
    logic              rd_q;
    logic              trigger;
    logic              asm_clear;
    logic [31:0]       asm_word;

    // Only a low-to-high done seen while idle starts a readback; done_q
    // resets high so a done already asserted at reset is not an edge.
    assign trigger = (state == IDLE) && done && !done_q;
    assign busy    = (state != IDLE);

    // The memory returns a byte one cycle after its address, so the shift
    // enable is simply the read strobe delayed by one cycle. This makes
    // the fourth byte land during CAPTURE, after mem_rd has dropped.
    rb_word_assembler u_assembler (
        .clk     (CLOCK_50),
        .reset   (reset),
        .clear   (asm_clear),
        .shift   (rd_q),
        .byte_in (mem_rdata),
        .word    (asm_word)
    );

`ifdef RB_STATS_EN
    logic [31:0] stats;

    // Counter snapshot taken on the trigger edge so the stats word reports
    // the counters as they were when the CPU finished, not at readout.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            stats <= '0;
        end else if (trigger) begin
            stats <= {clock_count, instr_cnt};
        end
    end

    // The stats word replaces the assembled word only while in STATS.
    assign out_data = (state == STATS) ? stats : asm_word;
`else
    logic [31:0] unused_counters;

    assign unused_counters = {clock_count, instr_cnt};
    assign out_data        = asm_word;
`endif

    // State, word/byte counters, the done edge detector and the delayed
    // read strobe. A reset anywhere drops straight back to idle, discarding
    // any partially built word.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            word_idx <= '0;
            byte_idx <= '0;
            done_q   <= 1'b1;
            rd_q     <= 1'b0;
        end else begin
            state    <= state_next;
            word_idx <= word_next;
            byte_idx <= byte_next;
            done_q   <= done;
            rd_q     <= mem_rd;
        end
    end

    // Next-state and output decode. Outputs come from the state register
    // only, so there is no combinational path from out_ready to out_valid.
    // The address is BASE + 4*word + byte, formed by concatenation and
    // wrapping naturally at ADDR_W bits.
    always_comb begin
        state_next = state;
        word_next  = word_idx;
        byte_next  = byte_idx;
        asm_clear  = 1'b0;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        out_valid  = 1'b0;
        out_last   = 1'b0;

        case (state)
            IDLE: begin
                if (trigger) begin
                    state_next = FETCH;
                    word_next  = '0;
                    byte_next  = '0;
                    asm_clear  = 1'b1;
                end
            end

            FETCH: begin
                mem_rd    = 1'b1;
                mem_addr  = BASE_ADDR + ADDR_W'({word_idx, byte_idx});
                byte_next = byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    state_next = CAPTURE;
                end
            end

            CAPTURE: begin
                state_next = PRESENT;
            end

            PRESENT: begin
                out_valid = 1'b1;
`ifdef RB_STATS_EN
                out_last  = 1'b0;
`else
                out_last  = (word_idx == LAST_WORD);
`endif
                if (out_ready) begin
                    if (word_idx != LAST_WORD) begin
                        word_next  = word_idx + WORD_W'(1);
                        byte_next  = '0;
                        asm_clear  = 1'b1;
                        state_next = FETCH;
                    end else begin
`ifdef RB_STATS_EN
                        state_next = STATS;
`else
                        state_next = IDLE;
`endif
                    end
                end
            end

            STATS: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
